// File: rtl/blit_regdec_if.sv
// rtl/blit_regdec_if.sv - GPU programming port and strobe bundle for the blitter register decoder.
interface blit_regdec_if #(
  parameter int NREGS = 32
);
  logic [23:0]      gpu_addr;
  logic             gpu_memw;
  logic             gpu_memr;
  logic             bliten;
  logic             blit_busy;
  logic [NREGS-1:0] ext_ld;
  logic [NREGS-1:0] ld;
  logic [NREGS-1:0] rd;
  logic             gpu_ack;
  logic             gpu_wait;
  logic             err;

  modport master (
    output gpu_addr, gpu_memw, gpu_memr, bliten, blit_busy, ext_ld,
    input  ld, rd, gpu_ack, gpu_wait, err
  );

  modport slave (
    input  gpu_addr, gpu_memw, gpu_memr, bliten, blit_busy, ext_ld,
    output ld, rd, gpu_ack, gpu_wait, err
  );
endinterface

// File: rtl/blit_regdec.sv
// rtl/blit_regdec.sv - windowed GPU register decoder with busy hold-off and registered one-hot strobes.
module blit_regdec #(
  parameter logic [23:0]      BASE_ADDR = 24'hF02200,
  parameter int               NREGS     = 32,
  parameter int               ADDR_LSB  = 2,
  parameter logic [NREGS-1:0] HOLD_MASK = 32'h0000_4000
) (
  input  logic          sys_clk,
  input  logic          reset,
  blit_regdec_if.slave  bus
);

  localparam int IDX_W      = $clog2(NREGS);
  localparam int TAG_LSB    = ADDR_LSB + IDX_W;
  localparam int STATUS_IDX = 14;

  typedef enum logic [1:0] {IDLE, HOLD, STROBE, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [NREGS-1:0] ld_q, ld_d;
  logic [NREGS-1:0] rd_q, rd_d;
  logic             ack_q, ack_d;
  logic             wait_q, wait_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] addr_idx;
  logic             hit;
  logic [NREGS-1:0] onehot;
  logic             strobe_d;

  assign addr_idx = bus.gpu_addr[ADDR_LSB +: IDX_W];
  assign hit = bus.bliten
             && (bus.gpu_addr[23:TAG_LSB] == BASE_ADDR[23:TAG_LSB])
             && ({{(32-IDX_W){1'b0}}, addr_idx} < 32'(NREGS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Write wins when both request lines are high.
        if (bus.gpu_memw) begin
          if (hit) begin
            idx_d   = addr_idx;
            wr_d    = 1'b1;
            state_d = (!bus.blit_busy || HOLD_MASK[addr_idx]) ? STROBE : HOLD;
          end
        end else if (bus.gpu_memr && hit) begin
          idx_d   = addr_idx;
          wr_d    = 1'b0;
          state_d = STROBE;
        end
      end
      HOLD: begin
        if (!bus.bliten || !bus.gpu_memw) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!bus.blit_busy) begin
          state_d = STROBE;
        end
      end
      STROBE: state_d = DONE;
      DONE: begin
        if (!bus.gpu_memw && !bus.gpu_memr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    onehot        = '0;
    onehot[idx_d] = 1'b1;
    strobe_d      = (state_d == STROBE);
    ld_d          = ((strobe_d && wr_d) ? onehot : '0) | bus.ext_ld;
    rd_d          = (strobe_d && !wr_d) ? onehot : '0;
    ack_d         = strobe_d;
    wait_d        = (state_d == HOLD);
    // A status read acknowledges a previously aborted held write.
    if (strobe_d && !wr_d && ({{(32-IDX_W){1'b0}}, idx_d} == 32'(STATUS_IDX))) err_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      ld_q    <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign bus.ld       = ld_q;
  assign bus.rd       = rd_q;
  assign bus.gpu_ack  = ack_q;
  assign bus.gpu_wait = wait_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_blit_regdec.sv
// tb/tb_blit_regdec.sv - directed and randomized checks of blit_regdec against a transaction timeline model.
module tb_blit_regdec;

  localparam logic [23:0] BASE  = 24'hF02200;
  localparam logic [31:0] HMASK = 32'h0000_4000;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_chk   = 0;
  int   n_err   = 0;

  blit_regdec_if #(.NREGS(32)) bus ();

  blit_regdec #(.NREGS(32)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [23:0] a,
                       input logic en, input logic bsy, input logic [31:0] ext);
    bus.gpu_memw  = w;
    bus.gpu_memr  = r;
    bus.gpu_addr  = a;
    bus.bliten    = en;
    bus.blit_busy = bsy;
    bus.ext_ld    = ext;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, BASE, 1'b1, 1'b0, 32'h0);
    repeat (n) @(negedge sys_clk);
  endtask

  logic [23:0] miss_addr [3] = '{24'hF02280, 24'hF01238, 24'hF02238};
  logic        miss_en   [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge sys_clk);
    check("rst_ld", bus.ld, 32'h0);
    check("rst_rd", bus.rd, 32'h0);
    check("rst_flags", {29'h0, bus.gpu_ack, bus.gpu_wait, bus.err}, 32'h0);
    reset = 1'b0;
    idle(2);

    // Unheld write to index 14, request held afterwards
    drive(1'b1, 1'b0, 24'hF02238, 1'b1, 1'b0, 32'h0);
    @(negedge sys_clk);
    check("a_ld", bus.ld, 32'h0000_4000);
    check("a_ack", 32'(bus.gpu_ack), 32'h1);
    repeat (5) begin
      @(negedge sys_clk);
      check("a_once_ld", bus.ld, 32'h0);
      check("a_once_ack", 32'(bus.gpu_ack), 32'h0);
    end
    idle(2);

    // Held write to index 1 for 10 busy cycles, ext_ld[5] during hold
    drive(1'b1, 1'b0, 24'hF02204, 1'b1, 1'b1, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge sys_clk);
      check("b_wait", 32'(bus.gpu_wait), 32'h1);
      check("b_ld", bus.ld, (c == 5) ? 32'h20 : 32'h0);
      bus.ext_ld = (c == 4) ? 32'h20 : 32'h0;
      if (c == 10) bus.blit_busy = 1'b0;
    end
    @(negedge sys_clk);
    check("b_ld_strobe", bus.ld, 32'h2);
    check("b_ack", 32'(bus.gpu_ack), 32'h1);
    check("b_wait_off", 32'(bus.gpu_wait), 32'h0);
    idle(2);

    // Index 14 bypasses busy hold-off; then read it
    drive(1'b1, 1'b0, 24'hF02238, 1'b1, 1'b1, 32'h0);
    @(negedge sys_clk);
    check("c_ld", bus.ld, 32'h0000_4000);
    check("c_wait", 32'(bus.gpu_wait), 32'h0);
    idle(2);
    drive(1'b0, 1'b1, 24'hF02238, 1'b1, 1'b1, 32'h0);
    @(negedge sys_clk);
    check("c_rd", bus.rd, 32'h0000_4000);
    check("c_rd_ld", bus.ld, 32'h0);
    check("c_rd_ack", 32'(bus.gpu_ack), 32'h1);
    idle(2);

    for (int m = 0; m < 3; m++) begin
      drive(1'b1, 1'b1, miss_addr[m], miss_en[m], 1'b0, 32'h0);
      repeat (3) begin
        @(negedge sys_clk);
        check("miss_ld", bus.ld, 32'h0);
        check("miss_rd", bus.rd, 32'h0);
        check("miss_ack", 32'(bus.gpu_ack), 32'h0);
      end
      idle(1);
    end

    // ext_ld[3] coincident with GPU write to index 3
    drive(1'b1, 1'b0, 24'hF0220C, 1'b1, 1'b0, 32'h8);
    @(negedge sys_clk);
    check("d_ld", bus.ld, 32'h8);
    bus.ext_ld = 32'h0;
    @(negedge sys_clk);
    check("d_single", bus.ld, 32'h0);
    idle(2);

    // Abort held write -> err
    drive(1'b1, 1'b0, 24'hF02204, 1'b1, 1'b1, 32'h0);
    @(negedge sys_clk);
    check("e_wait", 32'(bus.gpu_wait), 32'h1);
    bus.gpu_memw = 1'b0;
    @(negedge sys_clk);
    check("e_err", 32'(bus.err), 32'h1);
    check("e_wait_off", 32'(bus.gpu_wait), 32'h0);

    // Asynchronous reset in HOLD, then request decoded afresh
    drive(1'b1, 1'b0, 24'hF02204, 1'b1, 1'b1, 32'h1);
    @(negedge sys_clk);
    check("r_wait", 32'(bus.gpu_wait), 32'h1);
    check("r_ld_ext", bus.ld, 32'h1);
    check("r_err", 32'(bus.err), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("r_async_flags", {29'h0, bus.gpu_ack, bus.gpu_wait, bus.err}, 32'h0);
    check("r_async_ld", bus.ld, 32'h0);
    @(negedge sys_clk);
    reset = 1'b0;
    bus.ext_ld = 32'h0;
    @(negedge sys_clk);
    check("r_rehold", 32'(bus.gpu_wait), 32'h1);
    check("r_rehold_ld", bus.ld, 32'h0);
    bus.blit_busy = 1'b0;
    @(negedge sys_clk);
    check("r_strobe", bus.ld, 32'h2);
    idle(2);

    // err set, then cleared by a status read
    drive(1'b1, 1'b0, 24'hF02204, 1'b1, 1'b1, 32'h0);
    @(negedge sys_clk);
    bus.gpu_memw = 1'b0;
    @(negedge sys_clk);
    check("f_err_set", 32'(bus.err), 32'h1);
    drive(1'b0, 1'b1, 24'hF02238, 1'b1, 1'b0, 32'h0);
    @(negedge sys_clk);
    check("f_rd14", bus.rd, 32'h0000_4000);
    idle(1);
    check("f_err_clr", 32'(bus.err), 32'h0);
    idle(1);

    // Randomized transactions against a timeline model
    for (int n = 0; n < 150; n++) begin
      logic        wr, both, en, hit, held;
      logic [4:0]  idx;
      logic [23:0] addr;
      int          busyc, mk, s;
      logic [31:0] ext, eld, erd;
      wr    = 1'($urandom_range(0, 1));
      both  = 1'($urandom_range(0, 1));
      idx   = 5'($urandom_range(0, 31));
      busyc = $urandom_range(0, 4);
      mk    = $urandom_range(0, 7);
      addr  = BASE | (24'(idx) << 2);
      en    = 1'b1;
      if (mk == 0) addr = addr ^ (24'h1 << $urandom_range(7, 23));
      if (mk == 1) en = 1'b0;
      hit   = (mk > 1);
      held  = hit && wr && (busyc > 0) && !HMASK[idx];
      s     = held ? busyc + 1 : 1;
      for (int t = 0; t <= s + 3; t++) begin
        ext = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        drive((t <= s + 1) && wr, (t <= s + 1) && (!wr || both), addr, en, t < busyc, ext);
        @(negedge sys_clk);
        eld = ext | ((hit && wr && (t + 1 == s)) ? (32'h1 << idx) : 32'h0);
        erd = (hit && !wr && (t + 1 == s)) ? (32'h1 << idx) : 32'h0;
        check("rnd_ld", bus.ld, eld);
        check("rnd_rd", bus.rd, erd);
        check("rnd_ack", 32'(bus.gpu_ack), 32'(hit && (t + 1 == s)));
        check("rnd_wait", 32'(bus.gpu_wait), 32'(held && (t + 1 <= busyc)));
        check("rnd_err", 32'(bus.err), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/blit_regdec.md
# blit_regdec

Parametrised, registered register-file decoder for the blitter's GPU-side programming port. It maps a GPU long-word access inside a configurable address window to a one-hot load or read strobe per register. A per-register busy hold-off stalls writes to working registers while a blit is running. Strobes are issued through a request/acknowledge handshake so data is valid when consumed. The block sits between the GPU bus interface and the blitter register bank, generalising the fixed combinational strobe decode used there.

## Interface
- BASE_ADDR, 24'hF02200, window base; must be aligned to NREGS<<ADDR_LSB
- NREGS, 32, number of decoded registers (2..64)
- ADDR_LSB, 2, byte-address bits below the register index
- HOLD_MASK, 32'h0000_4000, NREGS bits; bit i=1 means register i is writable while blit_busy (default: command/stop register, index 14)
- IDX_W, $clog2(NREGS), derived; not overridden

- sys_clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- gpu_addr  in  24  GPU byte address
- gpu_memw  in  1  GPU write request, held until gpu_ack
- gpu_memr  in  1  GPU read request, held until gpu_ack
- bliten  in  1  blitter decode enable
- blit_busy  in  1  blit in progress
- ext_ld  in  NREGS  internal load requests (pointer write-back etc.), one-cycle pulses
- ld  out  NREGS  registered one-hot-or-ext load strobes
- rd  out  NREGS  registered one-hot read strobes
- gpu_ack  out  1  access accepted; coincident with ld/rd strobe
- gpu_wait  out  1  write held off by blit_busy
- err  out  1  sticky: write attempted while held, later aborted by reset of bliten

## Operation
- Hit: bliten=1, gpu_addr[23:ADDR_LSB+IDX_W] equals BASE_ADDR's same bits, index=gpu_addr[ADDR_LSB+:IDX_W] < NREGS. Misses are ignored (no ack, no strobe).
- gpu_memw and gpu_memr both high: write takes priority; read ignored.
- FSM states IDLE, HOLD, STROBE, DONE.
- IDLE: write hit with (!blit_busy or HOLD_MASK[index]) -> STROBE; write hit otherwise -> HOLD; read hit -> STROBE (reads never held). Index and direction latched on leaving IDLE.
- HOLD: gpu_wait=1. blit_busy=0 -> STROBE. bliten=0 or gpu_memw=0 -> IDLE with err set.
- STROBE: exactly one cycle. ld[idx] (write) or rd[idx] (read) =1, gpu_ack=1. Next state DONE.
- DONE: wait until gpu_memw=0 and gpu_memr=0, then IDLE. Prevents a held request from strobing twice.
- ld = (STROBE & write ? onehot(idx) : 0) | ext_ld, registered. Same register from both sources in one cycle yields a single pulse.
- err clears on rd strobe of index 14 (status read) or on reset.

## Timing
- Reset: state IDLE; ld, rd, gpu_ack, gpu_wait, err all 0.
- Unheld access: request in cycle N (IDLE) -> ld/rd and gpu_ack in cycle N+1 -> DONE from N+2.
- Held write: gpu_wait goes high in N+1. Strobe comes one cycle after the first sampled blit_busy=0.
- ext_ld pulse in cycle N -> ld in cycle N+1 in every state, including HOLD and DONE.
- Minimum spacing between GPU strobes: 3 cycles (STROBE, DONE, IDLE).
- Reset asserted mid-operation: outputs clear immediately, with no ack and no strobe. The pending access is lost, and the GPU side must re-issue it.
- Back-to-back ext_ld pulses produce back-to-back ld pulses.

## Test plan
- Reset mid-sequence: assert reset while in HOLD -> gpu_wait, ld, err drop to 0 asynchronously. After release, an unchanged held request is decoded afresh from IDLE.
- Write 0xF02238, busy=0 -> ld=32'h0000_4000 and gpu_ack one cycle later. With the request held for 5 more cycles, no second strobe occurs.
- Write 0xF02204 (index 1) with blit_busy=1 for 10 cycles -> gpu_wait high 10 cycles. ld[1] and gpu_ack follow one cycle after busy falls.
- Write 0xF02238 with blit_busy=1 -> index 14 is in HOLD_MASK, so ld[14] comes immediately with no gpu_wait. Read 0xF02238 -> rd[14].
- Miss cases: addresses 0xF02280 (index 32), 0xF01238, and any address with bliten=0 -> no strobe, no ack.
- ext_ld[3] pulse coincident with GPU write to index 3 -> single ld[3] pulse. ext_ld[5] during HOLD -> ld[5] while gpu_wait stays high.
- Held write to index 1, then gpu_memw dropped while busy -> err=1. A later rd[14] clears err.
